// File: rtl/alu_cmd_issue.sv
// rtl/alu_cmd_issue.sv - command FIFO plus operand/result registers around a combinational ALU
//
// Purpose: buffers ALU commands in a DEPTH-entry FIFO, registers the head
// command onto the ALU inputs (stage 1) and captures the ALU result, flags
// and tag into an output register (stage 2). Both sides use valid/ready.
// Optional feature macro: ALU_ISSUE_FWD_EN (adds cmd_fwd, forwards the
// previous command's result into operand A).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    synchronous clear of FIFO and both stages
//   cmd_valid/cmd_ready      command handshake; cmd_op/cmd_a/cmd_b/cmd_tag payload
//   cmd_fwd                  (ALU_ISSUE_FWD_EN only) replace A with previous result
//   alu_a/alu_b/alu_ctrl     operand register driving the ALU
//   alu_result, alu_zero, alu_greater, alu_less   from the ALU
//   res_valid/res_ready      result handshake; res_data/res_flags/res_tag payload
//   fifo_count               FIFO occupancy
module alu_cmd_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [31:0]              cmd_a,
    input  logic [31:0]              cmd_b,
    input  logic [TAG_W-1:0]         cmd_tag,
`ifdef ALU_ISSUE_FWD_EN
    input  logic                     cmd_fwd,
`endif
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [2:0]               alu_ctrl,
    input  logic [31:0]              alu_result,
    input  logic                     alu_zero,
    input  logic                     alu_greater,
    input  logic                     alu_less,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic [2:0]               res_flags,
    output logic [TAG_W-1:0]         res_tag,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 3 + 32 + 32 + TAG_W;

    // FIFO storage: {op, a, b, tag}
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
`ifdef ALU_ISSUE_FWD_EN
    logic             fwd_mem_q [DEPTH];
    logic             fwd_mem_d [DEPTH];
    logic [31:0]      last_result_q, last_result_d;
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             op_valid_q, op_valid_d;
    logic [31:0]      alu_a_q, alu_a_d;
    logic [31:0]      alu_b_q, alu_b_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [TAG_W-1:0] op_tag_q, op_tag_d;

    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [2:0]       res_flags_q, res_flags_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;

    logic             full, empty, push, op_adv, op_load;
    logic [ENT_W-1:0] head;
    logic [31:0]      head_a;

    always_comb begin
        mem_d = mem_q;
`ifdef ALU_ISSUE_FWD_EN
        fwd_mem_d     = fwd_mem_q;
        last_result_d = last_result_q;
`endif
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        op_valid_d  = op_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        op_tag_d    = op_tag_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        res_tag_d   = res_tag_q;

        full      = (cnt_q == CNT_W'(DEPTH));
        empty     = (cnt_q == '0);
        // No pass-through: a full FIFO refuses even if it pops this cycle.
        cmd_ready = !full;
        push      = cmd_valid && cmd_ready;
        op_adv    = op_valid_q && (!res_valid_q || res_ready);
        op_load   = !empty && (!op_valid_q || op_adv);
        head      = mem_q[rd_ptr_q];
        head_a    = head[TAG_W+63:TAG_W+32];
`ifdef ALU_ISSUE_FWD_EN
        // The previous command in program order is either still in the
        // operand register (advancing this edge, so its result is on the
        // ALU now) or already past it, in which case last_result holds it.
        if (fwd_mem_q[rd_ptr_q]) begin
            head_a = op_valid_q ? alu_result : last_result_q;
        end
`endif

        if (flush) begin
            // Control state clears; data registers hold their values and
            // any accept in this cycle is dropped.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            op_valid_d  = 1'b0;
            res_valid_d = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
            last_result_d = '0;
`endif
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {cmd_op, cmd_a, cmd_b, cmd_tag};
`ifdef ALU_ISSUE_FWD_EN
                fwd_mem_d[wr_ptr_q] = cmd_fwd;
`endif
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (op_load) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                alu_ctrl_d = head[ENT_W-1:ENT_W-3];
                alu_a_d    = head_a;
                alu_b_d    = head[TAG_W+31:TAG_W];
                op_tag_d   = head[TAG_W-1:0];
                op_valid_d = 1'b1;
            end else if (op_adv) begin
                op_valid_d = 1'b0;
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(op_load);

            if (op_adv) begin
                res_data_d  = alu_result;
                res_flags_d = {alu_greater, alu_less, alu_zero};
                res_tag_d   = op_tag_q;
                res_valid_d = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
                last_result_d = alu_result;
`endif
            end else if (res_ready) begin
                res_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
`ifdef ALU_ISSUE_FWD_EN
        fwd_mem_q <= fwd_mem_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            op_valid_q  <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            op_tag_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_tag_q   <= '0;
`ifdef ALU_ISSUE_FWD_EN
            last_result_q <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            op_valid_q  <= op_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            op_tag_q    <= op_tag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            res_tag_q   <= res_tag_d;
`ifdef ALU_ISSUE_FWD_EN
            last_result_q <= last_result_d;
`endif
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_flags  = res_flags_q;
    assign res_tag    = res_tag_q;
    assign fifo_count = cnt_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb/tb_alu_cmd_issue.sv - directed self-checking bench for alu_cmd_issue
module tb_alu_cmd_issue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst, flush, cmd_valid, cmd_ready;
    logic [2:0]        cmd_op;
    logic [31:0]       cmd_a, cmd_b;
    logic [TAG_W-1:0]  cmd_tag;
`ifdef ALU_ISSUE_FWD_EN
    logic              cmd_fwd;
`endif
    logic [31:0]       alu_a, alu_b, alu_result;
    logic [2:0]        alu_ctrl;
    logic              alu_zero, alu_greater, alu_less;
    logic              res_valid, res_ready;
    logic [31:0]       res_data;
    logic [2:0]        res_flags;
    logic [TAG_W-1:0]  res_tag;
    logic [$clog2(DEPTH):0] fifo_count;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [31:0]      got_data[$];
    logic [2:0]       got_flags[$];
    logic [TAG_W-1:0] got_tag[$];
    int               got_cyc[$];

    alu_cmd_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
`ifdef ALU_ISSUE_FWD_EN
        .cmd_fwd(cmd_fwd),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_greater(alu_greater), .alu_less(alu_less),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags), .res_tag(res_tag),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // External combinational ALU; flags derived from the signed result.
    always_comb begin
        case (alu_ctrl)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = alu_a << alu_b[4:0];
            3'd6: alu_result = alu_a >> alu_b[4:0];
            default: alu_result = alu_a;
        endcase
        alu_zero    = (alu_result == 32'd0);
        alu_less    = alu_result[31];
        alu_greater = !alu_result[31] && (alu_result != 32'd0);
    end

    // Record every completed result handshake.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && !flush && res_valid && res_ready) begin
            got_data.push_back(res_data);
            got_flags.push_back(res_flags);
            got_tag.push_back(res_tag);
            got_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        got_data.delete();
        got_flags.delete();
        got_tag.delete();
        got_cyc.delete();
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] tag);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
        cmd_fwd = 1'b0;
`endif
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        for (int k = 0; k < 60 && got_data.size() < n; k++) begin
            @(posedge clk); #1;
        end
        nvec++;
        if (got_data.size() != n) begin
            nerr++;
            $display("FAIL wait_results: got %0d results, need %0d", got_data.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL reset_res_valid: got %b need 0", res_valid); end
        nvec++; if (fifo_count !== 0) begin nerr++; $display("FAIL reset_count: got %0d need 0", fifo_count); end
        nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL reset_cmd_ready: got %b need 1", cmd_ready); end
        nvec++; if ({alu_a, alu_b, alu_ctrl} !== 67'd0) begin nerr++; $display("FAIL reset_alu_regs: got %h %h %h need 0", alu_a, alu_b, alu_ctrl); end
        nvec++; if ({res_data, res_flags, res_tag} !== '0) begin nerr++; $display("FAIL reset_res_regs: got %h %b %h need 0", res_data, res_flags, res_tag); end
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        clear_log();
        push_cmd(3'd0, 32'd5, 32'd1, 4'd3);
        nvec++; if (fifo_count !== 1) begin nerr++; $display("FAIL single_count_e0: got %0d need 1", fifo_count); end
        nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL single_valid_e0: got %b need 0", res_valid); end
        @(posedge clk); #1;
        nvec++; if ({alu_ctrl, alu_a, alu_b} !== {3'd0, 32'd5, 32'd1}) begin nerr++; $display("FAIL single_operands: got %0d %0d %0d need 0 5 1", alu_ctrl, alu_a, alu_b); end
        nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL single_valid_e1: got %b need 0", res_valid); end
        @(posedge clk); #1;
        nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL single_valid_e2: got %b need 1", res_valid); end
        nvec++; if (res_data !== 32'd6) begin nerr++; $display("FAIL single_data: got %0d need 6", res_data); end
        nvec++; if (res_flags !== 3'b100) begin nerr++; $display("FAIL single_flags: got %b need 100", res_flags); end
        nvec++; if (res_tag !== 4'd3) begin nerr++; $display("FAIL single_tag: got %0d need 3", res_tag); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3] = '{32'd510, 32'd255, 32'd0};
        res_ready = 1'b1;
        clear_log();
        push_cmd(3'd0, 32'd255, 32'd255, 4'd1);
        push_cmd(3'd7, 32'd255, 32'd255, 4'd2);
        push_cmd(3'd1, 32'd255, 32'd255, 4'd3);
        wait_results(3);
        if (got_data.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                nvec++; if (got_data[i] !== exp_d[i]) begin nerr++; $display("FAIL b2b_data[%0d]: got %0d need %0d", i, got_data[i], exp_d[i]); end
                nvec++; if (got_tag[i] !== 4'(i + 1)) begin nerr++; $display("FAIL b2b_tag[%0d]: got %0d need %0d", i, got_tag[i], i + 1); end
            end
            nvec++; if (got_flags[2] !== 3'b001) begin nerr++; $display("FAIL b2b_zero_flag: got %b need 001", got_flags[2]); end
            nvec++; if (got_cyc[2] - got_cyc[0] != 2) begin nerr++; $display("FAIL b2b_spacing: got %0d cycles need 2", got_cyc[2] - got_cyc[0]); end
        end
    endtask

    task automatic test_stall_full();
        logic [31:0] hold_a, hold_d;
        res_ready = 1'b0;
        clear_log();
        for (int i = 0; i < DEPTH + 2; i++) push_cmd(3'd0, 32'(100 + i), 32'(i), 4'(i));
        nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL full_cmd_ready: got %b need 0", cmd_ready); end
        nvec++; if (fifo_count !== DEPTH) begin nerr++; $display("FAIL full_count: got %0d need %0d", fifo_count, DEPTH); end
        nvec++; if (res_valid !== 1'b1 || res_data !== 32'd100) begin nerr++; $display("FAIL stall_head: got v=%b d=%0d need v=1 d=100", res_valid, res_data); end
        hold_a = alu_a; hold_d = res_data;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (alu_a !== 32'd101 || alu_a !== hold_a || res_data !== hold_d) begin nerr++; $display("FAIL stall_hold: got a=%0d d=%0d need a=101 d=100", alu_a, res_data); end
        // Full FIFO with a pop this cycle: still refuses the offered command.
        cmd_op = 3'd0; cmd_a = 32'd999; cmd_b = 32'd0; cmd_tag = 4'hF; cmd_valid = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
        cmd_fwd = 1'b0;
`endif
        res_ready = 1'b1;
        #1;
        nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL full_pop_ready: got %b need 0", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        nvec++; if (fifo_count !== DEPTH - 1) begin nerr++; $display("FAIL full_pop_count: got %0d need %0d", fifo_count, DEPTH - 1); end
        wait_results(DEPTH + 2);
        if (got_data.size() == DEPTH + 2) begin
            for (int i = 0; i < DEPTH + 2; i++) begin
                nvec++; if (got_data[i] !== 32'(100 + 2 * i) || got_tag[i] !== 4'(i)) begin nerr++; $display("FAIL drain[%0d]: got %0d/%0d need %0d/%0d", i, got_data[i], got_tag[i], 100 + 2 * i, i); end
            end
        end
    endtask

    task automatic test_mid_reset();
        res_ready = 1'b1;
        clear_log();
        push_cmd(3'd0, 32'd1, 32'd1, 4'd1);
        push_cmd(3'd0, 32'd2, 32'd2, 4'd2);
        push_cmd(3'd0, 32'd3, 32'd3, 4'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nvec++; if (res_valid !== 1'b0 || fifo_count !== 0) begin nerr++; $display("FAIL midrst_state: got v=%b cnt=%0d need 0 0", res_valid, fifo_count); end
        nvec++; if ({alu_a, alu_b, alu_ctrl, res_data, res_flags, res_tag} !== '0) begin nerr++; $display("FAIL midrst_regs: got a=%0d d=%0d need 0", alu_a, res_data); end
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (got_data.size() != 0) begin nerr++; $display("FAIL midrst_leak: got %0d results need 0", got_data.size()); end
        push_cmd(3'd4, 32'hF0, 32'hFF, 4'd9);
        wait_results(1);
        if (got_data.size() == 1) begin
            nvec++; if (got_data[0] !== 32'h0F || got_tag[0] !== 4'd9) begin nerr++; $display("FAIL midrst_new: got %h/%0d need 0f/9", got_data[0], got_tag[0]); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] saved_d;
        res_ready = 1'b0;
        clear_log();
        saved_d = res_data;
        push_cmd(3'd3, 32'h10, 32'h01, 4'd4);
        push_cmd(3'd3, 32'h20, 32'h02, 4'd5);
        flush = 1'b1;
        cmd_op = 3'd0; cmd_a = 32'd7; cmd_b = 32'd7; cmd_tag = 4'd6; cmd_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; cmd_valid = 1'b0;
        nvec++; if (res_valid !== 1'b0 || fifo_count !== 0) begin nerr++; $display("FAIL flush_state: got v=%b cnt=%0d need 0 0", res_valid, fifo_count); end
        nvec++; if (alu_a !== 32'h10 || res_data !== saved_d) begin nerr++; $display("FAIL flush_hold: got a=%h d=%h need 10 %h", alu_a, res_data, saved_d); end
        res_ready = 1'b1;
        push_cmd(3'd2, 32'hFF, 32'h3C, 4'd7);
        wait_results(1);
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (got_data.size() != 1 || got_data[0] !== 32'h3C || got_tag[0] !== 4'd7) begin nerr++; $display("FAIL flush_after: got n=%0d d=%h need 1 3c", got_data.size(), got_data[0]); end
    endtask

`ifdef ALU_ISSUE_FWD_EN
    task automatic test_forward();
        res_ready = 1'b1;
        clear_log();
        push_cmd(3'd0, 32'd3, 32'd4, 4'd1);
        cmd_op = 3'd0; cmd_a = 32'd12345; cmd_b = 32'd10; cmd_tag = 4'd2; cmd_fwd = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_fwd = 1'b0;
        wait_results(2);
        if (got_data.size() == 2) begin
            nvec++; if (got_data[0] !== 32'd7 || got_data[1] !== 32'd17) begin nerr++; $display("FAIL fwd: got %0d %0d need 7 17", got_data[0], got_data[1]); end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
`ifdef ALU_ISSUE_FWD_EN
        cmd_fwd = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_stall_full();
        test_mid_reset();
        test_flush();
`ifdef ALU_ISSUE_FWD_EN
        test_forward();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
- Upstream issue stage for the 32-bit combinational ALU.
- Buffers ALU commands (opcode, A, B, tag) in a FIFO and registers operands onto the ALU inputs.
- Captures the ALU result and flags into an output register with valid/ready handshakes on both sides.
- Turns the purely combinational ALU into a 2-stage, back-pressurable pipeline.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, >=2
- TAG_W, 4, width of the opaque command tag carried with each operation

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  sync clear of FIFO and both stages; ignored while rst is high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_op  in  3  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 pass A
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- cmd_tag  in  TAG_W  returned with the result
- alu_a  out  32  to ALU A (operand register)
- alu_b  out  32  to ALU B
- alu_ctrl  out  3  to ALU opcode
- alu_result  in  32  from ALU
- alu_zero, alu_greater, alu_less  in  1 each  ALU flags
- res_valid  out  1  result register holds data
- res_ready  in  1  consumer accepts
- res_data  out  32  captured result
- res_flags  out  3  {greater, less, zero} captured
- res_tag  out  TAG_W  tag of the result
- fifo_count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO pointers and count cleared.
  - op_valid=0, res_valid=0.
  - alu_a, alu_b, alu_ctrl, res_data, res_flags, res_tag = 0; cmd_ready=1.
  - Mid-operation reset discards all in-flight commands; no result is emitted.
- flush: same clearing as rst except data registers keep their values. An accept in the same cycle as flush is discarded.
- FIFO:
  - push = cmd_valid & cmd_ready; pop = !empty & op_load.
  - Push and pop in the same cycle leave count unchanged.
  - When full, cmd_ready=0 even if a pop occurs that cycle (no pass-through).
  - Pointers wrap modulo DEPTH.
- Stage 1, operand register:
  - op_valid qualifies alu_a/alu_b/alu_ctrl.
  - op_load = !empty & (!op_valid | op_adv).
  - The head entry loads at the edge.
- Stage 2, result register:
  - op_adv = op_valid & (!res_valid | res_ready).
  - At the edge, alu_result and flags and the tag are captured and res_valid=1.
  - If res_valid & res_ready with no op_adv, res_valid goes to 0.
- Stall: res_valid & !res_ready holds both stages stable. res_* and alu_* do not change while stalled.
- Latency: command accepted at edge E0 -> operands on ALU after E1 -> res_valid after E2. Minimum 2 cycles accept-to-result.
- Throughput: 1 result/cycle with res_ready held high.
- Ordering: strictly in order; no drop or duplication.
- Width rules: operands and result are 32-bit, with no carry/overflow output. The ALU computes the flags from its result, and the result register stores them unchanged.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- When defined:
  - Extra input cmd_fwd (1 bit) is stored per FIFO entry.
  - At op_load, a set cmd_fwd replaces operand A with the result of the previous command in program order.
  - If the previous command is in the operand register at that edge, alu_result is used.
  - Otherwise an internal last_result register is used, updated on every op_adv, reset to 0, and cleared by flush.
  - cmd_a is ignored for that command.
- When undefined: no cmd_fwd port; operand A always comes from cmd_a.

Test Plan:
- rst, then push {op=0,a=5,b=1}, res_ready=1 -> res_valid 2 cycles after accept, res_data=6, flags={1,0,0}.
- Push {0,255,255},{7,255,255},{1,255,255} back-to-back -> results 510, 255, 0 on consecutive cycles; last flags zero=1. Tags returned in order.
- res_ready=0, push DEPTH+2 commands -> 2 held in the stages, DEPTH in FIFO, cmd_ready=0, fifo_count=DEPTH. Release res_ready -> all DEPTH+2 results in order.
- FIFO full with a pop in the same cycle -> cmd_ready stays 0 that cycle; count decrements by 1.
- Assert rst with 3 commands in flight -> next cycle res_valid=0, fifo_count=0, outputs 0. A new command then gives the correct result with no stale data.
- With ALU_ISSUE_FWD_EN: push {0,3,4} then {0,x,10,fwd=1} back-to-back -> results 7, 17.
